// File: rtl/serial_row_receiver.sv
// Serial row receiver: turns a bit-serial, MSB-first byte stream framed per row
// by `valid` into DEPTH-byte pixel words. Each pixel is tagged with its column
// flags and row index and sent out over a valid/ready handshake through a
// 2-entry FIFO.
//
// Ports:
//   clock, reset           rising-edge clock, async active-low reset
//   unproc_clk, data_in    bit strobe (active when sampled 0) and serial data
//   valid                  row frame from the sender
//   line_free, rx_ready    core line-buffer space in, row grant to sender out
//   px_*                   pixel stream (data, valid, ready, first, last, row)
//   frame_done             single-cycle pulse after the last row of a frame
//   clear_err, err_*       sticky error flags and their synchronous clear
module serial_row_receiver #(
    parameter int unsigned WIDTH  = 200,
    parameter int unsigned HEIGHT = 250,
    parameter int unsigned DEPTH  = 3
) (
    input  logic                                           clock,
    input  logic                                           reset,
    input  logic                                           unproc_clk,
    input  logic                                           data_in,
    input  logic                                           valid,
    input  logic                                           line_free,
    output logic                                           rx_ready,
    output logic [8*DEPTH-1:0]                             px_data,
    output logic                                           px_valid,
    input  logic                                           px_ready,
    output logic                                           px_first,
    output logic                                           px_last,
    output logic [((HEIGHT > 1) ? $clog2(HEIGHT) : 1)-1:0] px_row,
    output logic                                           frame_done,
    input  logic                                           clear_err,
    output logic                                           err_short,
    output logic                                           err_long,
    output logic                                           err_overrun
);

    localparam int unsigned PXW       = 8 * DEPTH;
    localparam int unsigned ROWW      = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int unsigned COLW      = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned LANEW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned ROW_BYTES = WIDTH * DEPTH;
    localparam int unsigned BCW       = $clog2(ROW_BYTES + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROW   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic              rx_ready_nxt;
    logic              set_short, set_long, set_overrun;

    logic [2:0]        bit_cnt;
    logic [6:0]        shift;
    logic [LANEW-1:0]  lane;
    logic [BCW-1:0]    byte_cnt;
    logic [PXW-1:0]    asm_px;
    logic              push_req;
    logic [ROWW-1:0]   push_row;
    logic [COLW-1:0]   col_cnt;
    logic [ROWW-1:0]   row_cnt;

    // Second FIFO entry; the first entry is the registered output itself.
    logic              s_valid;
    logic [PXW-1:0]    s_data;
    logic              s_first, s_last;
    logic [ROWW-1:0]   s_row;

    logic              strobe, capture, byte_done, px_done, row_full;
    logic              row_start, row_exit, pop;
    logic [7:0]        new_byte;
    logic              nw_first, nw_last;

    // Capture qualifiers and counter terminal conditions.
    assign strobe    = !unproc_clk;
    assign capture   = (state == ROW) && valid && strobe;
    assign new_byte  = {shift, data_in};
    assign byte_done = capture && (bit_cnt == 3'd7);
    assign px_done   = byte_done && (lane == LANEW'(DEPTH - 1));
    assign row_full  = byte_done && (byte_cnt == BCW'(ROW_BYTES - 1));
    assign row_start = (state == IDLE) && valid;
    assign row_exit  = (state == ROW) && (!valid || row_full);
    assign pop       = px_valid && px_ready;
    assign nw_first  = (col_cnt == '0);
    assign nw_last   = (col_cnt == COLW'(WIDTH - 1));

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            rx_ready <= 1'b0;
        end else begin
            state    <= state_nxt;
            rx_ready <= rx_ready_nxt;
        end
    end

    // Next state, row grant and error set conditions.
    always_comb begin
        state_nxt    = state;
        rx_ready_nxt = 1'b0;
        set_short    = 1'b0;
        set_long     = 1'b0;
        set_overrun  = push_req && px_valid && s_valid && !pop;
        case (state)
            IDLE: begin
                rx_ready_nxt = line_free;
                if (valid) begin
                    state_nxt    = ROW;
                    rx_ready_nxt = 1'b0;
                end
            end
            ROW: begin
                if (!valid) begin
                    state_nxt = IDLE;
                    set_short = (byte_cnt != BCW'(ROW_BYTES));
                end else if (row_full) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (!valid) begin
                    state_nxt = IDLE;
                end else if (strobe) begin
                    set_long = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Bit/byte assembly and column counter; counters restart with each row.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            bit_cnt  <= '0;
            shift    <= '0;
            lane     <= '0;
            byte_cnt <= '0;
            asm_px   <= '0;
            push_req <= 1'b0;
            push_row <= '0;
            col_cnt  <= '0;
        end else begin
            push_req <= px_done;
            if (px_done) begin
                push_row <= row_cnt;
            end
            if (row_start) begin
                bit_cnt  <= '0;
                shift    <= '0;
                lane     <= '0;
                byte_cnt <= '0;
                col_cnt  <= '0;
            end else begin
                if (push_req) begin
                    col_cnt <= col_cnt + COLW'(1);
                end
                if (capture) begin
                    shift   <= new_byte[6:0];
                    bit_cnt <= bit_cnt + 3'd1;
                    if (byte_done) begin
                        for (int k = 0; k < int'(DEPTH); k++) begin
                            if (lane == LANEW'(k)) begin
                                asm_px[8*k +: 8] <= new_byte;
                            end
                        end
                        lane     <= px_done ? '0 : lane + LANEW'(1);
                        byte_cnt <= byte_cnt + BCW'(1);
                    end
                end
            end
        end
    end

    // Row counter and end-of-frame pulse.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            row_cnt    <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (row_exit) begin
                if (row_cnt == ROWW'(HEIGHT - 1)) begin
                    row_cnt    <= '0;
                    frame_done <= 1'b1;
                end else begin
                    row_cnt <= row_cnt + ROWW'(1);
                end
            end
        end
    end

    // Two-entry output FIFO: output registers plus one skid entry.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            px_valid <= 1'b0;
            px_data  <= '0;
            px_first <= 1'b0;
            px_last  <= 1'b0;
            px_row   <= '0;
            s_valid  <= 1'b0;
            s_data   <= '0;
            s_first  <= 1'b0;
            s_last   <= 1'b0;
            s_row    <= '0;
        end else if (pop) begin
            if (s_valid) begin
                px_data  <= s_data;
                px_first <= s_first;
                px_last  <= s_last;
                px_row   <= s_row;
                if (push_req) begin
                    s_data  <= asm_px;
                    s_first <= nw_first;
                    s_last  <= nw_last;
                    s_row   <= push_row;
                end else begin
                    s_valid <= 1'b0;
                end
            end else if (push_req) begin
                px_data  <= asm_px;
                px_first <= nw_first;
                px_last  <= nw_last;
                px_row   <= push_row;
            end else begin
                px_valid <= 1'b0;
            end
        end else if (push_req && !px_valid) begin
            px_valid <= 1'b1;
            px_data  <= asm_px;
            px_first <= nw_first;
            px_last  <= nw_last;
            px_row   <= push_row;
        end else if (push_req && !s_valid) begin
            s_valid <= 1'b1;
            s_data  <= asm_px;
            s_first <= nw_first;
            s_last  <= nw_last;
            s_row   <= push_row;
        end
    end

    // Sticky errors; a new error wins over a coincident clear.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            err_short   <= 1'b0;
            err_long    <= 1'b0;
            err_overrun <= 1'b0;
        end else begin
            err_short   <= set_short   | (err_short   & ~clear_err);
            err_long    <= set_long    | (err_long    & ~clear_err);
            err_overrun <= set_overrun | (err_overrun & ~clear_err);
        end
    end

endmodule

// File: tb/tb_serial_row_receiver.sv
// Self-checking bench for serial_row_receiver with WIDTH=4, HEIGHT=3, DEPTH=3.
// A table of row transfers with hand-computed pixels and flags is applied in a
// loop; overrun and mid-row reset are covered by hand-written sequences.
module tb_serial_row_receiver;

    logic        clock;
    logic        reset;
    logic        unproc_clk;
    logic        data_in;
    logic        valid;
    logic        line_free;
    logic        rx_ready;
    logic [23:0] px_data;
    logic        px_valid;
    logic        px_ready;
    logic        px_first;
    logic        px_last;
    logic [1:0]  px_row;
    logic        frame_done;
    logic        clear_err;
    logic        err_short;
    logic        err_long;
    logic        err_overrun;

    serial_row_receiver #(
        .WIDTH (4),
        .HEIGHT(3),
        .DEPTH (3)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .unproc_clk (unproc_clk),
        .data_in    (data_in),
        .valid      (valid),
        .line_free  (line_free),
        .rx_ready   (rx_ready),
        .px_data    (px_data),
        .px_valid   (px_valid),
        .px_ready   (px_ready),
        .px_first   (px_first),
        .px_last    (px_last),
        .px_row     (px_row),
        .frame_done (frame_done),
        .clear_err  (clear_err),
        .err_short  (err_short),
        .err_long   (err_long),
        .err_overrun(err_overrun)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [23:0] d;
        logic        f;
        logic        l;
        logic [1:0]  r;
    } pix_t;

    typedef struct {
        int               nbytes;
        logic [7:0]       base;
        int               npix;
        logic [3:0][23:0] px;
        logic [1:0]       row;
        logic             e_short;
        logic             e_long;
        int               n_fd;
    } vec_t;

    pix_t got_q[$];
    int   fd_total = 0;
    int   n_vec    = 0;
    int   n_bad    = 0;
    vec_t vecs[6];

    // Transfer and frame_done monitor, sampled on the falling edge.
    always @(negedge clock) begin
        if (px_valid && px_ready) begin
            got_q.push_back('{d: px_data, f: px_first, l: px_last, r: px_row});
        end
        if (frame_done) begin
            fd_total++;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) begin
            data_in    = b[i];
            unproc_clk = 1'b0;
            tick();
        end
        unproc_clk = 1'b1;
    endtask

    task automatic wait_rx_ready();
        int n = 0;
        while (!rx_ready && n < 50) begin
            tick();
            n++;
        end
        chk("rx_ready_wait", 32'(rx_ready), 32'd1);
    endtask

    task automatic send_row(input int nbytes, input logic [7:0] base);
        wait_rx_ready();
        valid      = 1'b1;
        unproc_clk = 1'b1;
        tick();
        for (int i = 0; i < nbytes; i++) begin
            send_byte(8'(base + 8'(i)));
        end
        unproc_clk = 1'b1;
        valid      = 1'b0;
        repeat (6) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base_idx;
        int fd_base;

        vecs[0] = '{nbytes: 12, base: 8'h01, npix: 4,
                    px: {24'h0C0B0A, 24'h090807, 24'h060504, 24'h030201},
                    row: 2'd0, e_short: 1'b0, e_long: 1'b0, n_fd: 0};
        vecs[1] = '{nbytes: 12, base: 8'h10, npix: 4,
                    px: {24'h1B1A19, 24'h181716, 24'h151413, 24'h121110},
                    row: 2'd1, e_short: 1'b0, e_long: 1'b0, n_fd: 0};
        vecs[2] = '{nbytes: 12, base: 8'h20, npix: 4,
                    px: {24'h2B2A29, 24'h282726, 24'h252423, 24'h222120},
                    row: 2'd2, e_short: 1'b0, e_long: 1'b0, n_fd: 1};
        vecs[3] = '{nbytes: 12, base: 8'h30, npix: 4,
                    px: {24'h3B3A39, 24'h383736, 24'h353433, 24'h323130},
                    row: 2'd0, e_short: 1'b0, e_long: 1'b0, n_fd: 0};
        vecs[4] = '{nbytes: 7, base: 8'h40, npix: 2,
                    px: {24'h000000, 24'h000000, 24'h454443, 24'h424140},
                    row: 2'd1, e_short: 1'b1, e_long: 1'b0, n_fd: 0};
        vecs[5] = '{nbytes: 13, base: 8'h50, npix: 4,
                    px: {24'h5B5A59, 24'h585756, 24'h555453, 24'h525150},
                    row: 2'd2, e_short: 1'b0, e_long: 1'b1, n_fd: 1};

        reset      = 1'b0;
        unproc_clk = 1'b1;
        data_in    = 1'b0;
        valid      = 1'b0;
        line_free  = 1'b1;
        px_ready   = 1'b1;
        clear_err  = 1'b0;
        repeat (3) tick();

        // Everything quiet under reset, even with line_free high.
        chk("rst_rx_ready", 32'(rx_ready), 32'd0);
        chk("rst_px_valid", 32'(px_valid), 32'd0);
        chk("rst_px_data", 32'(px_data), 32'd0);
        chk("rst_flags", 32'({px_first, px_last, px_row, frame_done}), 32'd0);
        chk("rst_errs", 32'({err_short, err_long, err_overrun}), 32'd0);

        line_free = 1'b0;
        reset     = 1'b1;
        repeat (2) tick();
        chk("rx_ready_lf0", 32'(rx_ready), 32'd0);
        line_free = 1'b1;
        @(negedge clock);
        chk("rx_ready_lat0", 32'(rx_ready), 32'd0);
        @(posedge clock);
        #1;
        chk("rx_ready_lat1", 32'(rx_ready), 32'd1);

        for (int v = 0; v < 6; v++) begin
            base_idx = got_q.size();
            fd_base  = fd_total;
            send_row(vecs[v].nbytes, vecs[v].base);
            chk($sformatf("v%0d_npix", v), 32'(got_q.size() - base_idx), 32'(vecs[v].npix));
            for (int k = 0; k < vecs[v].npix; k++) begin
                if (base_idx + k < got_q.size()) begin
                    chk($sformatf("v%0d_p%0d_data", v, k), 32'(got_q[base_idx + k].d),
                        32'(vecs[v].px[k]));
                    chk($sformatf("v%0d_p%0d_first", v, k), 32'(got_q[base_idx + k].f),
                        32'(k == 0));
                    chk($sformatf("v%0d_p%0d_last", v, k), 32'(got_q[base_idx + k].l),
                        32'(k == 3));
                    chk($sformatf("v%0d_p%0d_row", v, k), 32'(got_q[base_idx + k].r),
                        32'(vecs[v].row));
                end
            end
            chk($sformatf("v%0d_err_short", v), 32'(err_short), 32'(vecs[v].e_short));
            chk($sformatf("v%0d_err_long", v), 32'(err_long), 32'(vecs[v].e_long));
            chk($sformatf("v%0d_err_overrun", v), 32'(err_overrun), 32'd0);
            chk($sformatf("v%0d_frame_done", v), 32'(fd_total - fd_base), 32'(vecs[v].n_fd));
            chk($sformatf("v%0d_rx_ready", v), 32'(rx_ready), 32'd1);
            clear_err = 1'b1;
            tick();
            clear_err = 1'b0;
            chk($sformatf("v%0d_cleared", v), 32'({err_short, err_long, err_overrun}), 32'd0);
        end

        // Stalled consumer: two pixels retained, the rest dropped.
        px_ready = 1'b0;
        base_idx = got_q.size();
        send_row(12, 8'h60);
        chk("ovr_err_overrun", 32'(err_overrun), 32'd1);
        chk("ovr_px_valid", 32'(px_valid), 32'd1);
        chk("ovr_head_data", 32'(px_data), 32'h626160);
        px_ready = 1'b1;
        repeat (5) tick();
        chk("ovr_npix", 32'(got_q.size() - base_idx), 32'd2);
        if (got_q.size() - base_idx >= 2) begin
            chk("ovr_p0_data", 32'(got_q[base_idx].d), 32'h626160);
            chk("ovr_p0_first", 32'(got_q[base_idx].f), 32'd1);
            chk("ovr_p1_data", 32'(got_q[base_idx + 1].d), 32'h656463);
            chk("ovr_p1_row", 32'(got_q[base_idx + 1].r), 32'd0);
        end
        chk("ovr_drained", 32'(px_valid), 32'd0);
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;

        // Reset in the middle of a row with a pixel waiting in the FIFO.
        px_ready = 1'b0;
        wait_rx_ready();
        valid = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            send_byte(8'(8'h70 + 8'(i)));
        end
        tick();
        chk("mid_px_valid_before", 32'(px_valid), 32'd1);
        reset = 1'b0;
        #1;
        chk("mid_px_valid_rst", 32'(px_valid), 32'd0);
        chk("mid_rx_ready_rst", 32'(rx_ready), 32'd0);
        valid    = 1'b0;
        px_ready = 1'b1;
        tick();
        reset = 1'b1;
        tick();
        base_idx = got_q.size();
        send_row(12, 8'h80);
        chk("post_rst_npix", 32'(got_q.size() - base_idx), 32'd4);
        if (got_q.size() > base_idx) begin
            chk("post_rst_p0_data", 32'(got_q[base_idx].d), 32'h828180);
            chk("post_rst_p0_row", 32'(got_q[base_idx].r), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
